// File: rtl/chip_io_bridge.sv
// rtl/chip_io_bridge.sv - pad-level bridge between narrow chip pins and wide request/response channels (optional RX timeout: CHIP_IO_BRIDGE_TIMEOUT_EN)
module chip_io_bridge #(
  parameter int PAD_W       = 12,
  parameter int REQ_W       = 40,
  parameter int RSP_W       = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PAD_W-1:0] in_bits,
  output logic [PAD_W-1:0] out_bits,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [REQ_W-1:0] req_data,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [RSP_W-1:0] rsp_data,
  output logic             rx_timeout
);

  localparam int DW        = PAD_W - 2;
  localparam int REQ_BEATS = (REQ_W + DW - 1) / DW;
  localparam int RSP_BEATS = (RSP_W + DW - 1) / DW;
  localparam int RX_CW     = (REQ_BEATS > 1) ? $clog2(REQ_BEATS) : 1;
  localparam int TX_CW     = (RSP_BEATS > 1) ? $clog2(RSP_BEATS) : 1;
  localparam int RXW       = REQ_BEATS * DW;
  localparam int TXW       = RSP_BEATS * DW;

  localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(REQ_BEATS - 1);
  localparam logic [TX_CW-1:0] TX_LAST = TX_CW'(RSP_BEATS - 1);

  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // Pad input fields
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  assign in_valid  = in_bits[PAD_W-1];
  assign out_ready = in_bits[PAD_W-2];
  assign in_data   = in_bits[DW-1:0];

  // RX state
  rx_state_t        rx_state_q, rx_state_d;
  logic [RX_CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [RXW-1:0]   asm_q, asm_d;
  logic             req_valid_q, req_valid_d;
  logic             in_ack_q, in_ack_d;
  logic             rx_timeout_q, rx_timeout_d;
  logic             in_fire;

  // TX state
  tx_state_t        tx_state_q, tx_state_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [TXW-1:0]   tx_sh_q, tx_sh_d;

  assign in_fire = in_valid & in_ack_q;

`ifdef CHIP_IO_BRIDGE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  // RX next state: assemble beats into the request register, then hold it until accepted
  always_comb begin
    rx_state_d   = rx_state_q;
    beat_cnt_d   = beat_cnt_q;
    asm_d        = asm_q;
    req_valid_d  = req_valid_q;
    in_ack_d     = in_ack_q;
    rx_timeout_d = 1'b0;
`ifdef CHIP_IO_BRIDGE_TIMEOUT_EN
    idle_cnt_d   = '0;
`endif
    case (rx_state_q)
      RX_COLLECT: begin
        in_ack_d    = 1'b1;
        req_valid_d = 1'b0;
        if (in_fire) begin
          for (int i = 0; i < REQ_BEATS; i++) begin
            if (beat_cnt_q == RX_CW'(i)) asm_d[i*DW +: DW] = in_data;
          end
          if (beat_cnt_q == RX_LAST) begin
            rx_state_d  = RX_HOLD;
            beat_cnt_d  = '0;
            req_valid_d = 1'b1;
            in_ack_d    = 1'b0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
`ifdef CHIP_IO_BRIDGE_TIMEOUT_EN
        else if (beat_cnt_q != '0) begin
          if (idle_cnt_q == TO_LAST) begin
            beat_cnt_d   = '0;
            asm_d        = '0;
            rx_timeout_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
`endif
      end
      RX_HOLD: begin
        if (req_ready) begin
          rx_state_d  = RX_COLLECT;
          req_valid_d = 1'b0;
          in_ack_d    = 1'b1;
        end
      end
      default: rx_state_d = RX_COLLECT;
    endcase
  end

  // RX registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q   <= RX_COLLECT;
      beat_cnt_q   <= '0;
      asm_q        <= '0;
      req_valid_q  <= 1'b0;
      in_ack_q     <= 1'b0;
      rx_timeout_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      beat_cnt_q   <= beat_cnt_d;
      asm_q        <= asm_d;
      req_valid_q  <= req_valid_d;
      in_ack_q     <= in_ack_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

`ifdef CHIP_IO_BRIDGE_TIMEOUT_EN
  // Idle counter for a partially assembled request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_cnt_q <= '0;
    else          idle_cnt_q <= idle_cnt_d;
  end
  assign rx_timeout = rx_timeout_q;
`else
  assign rx_timeout = 1'b0;
`endif

  // TX next state: capture a response, then shift it out one field per pad transfer
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_sh_d    = tx_sh_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (rsp_valid) begin
          tx_sh_d    = TXW'(rsp_data);
          tx_cnt_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (out_ready) begin
          tx_sh_d = tx_sh_q >> DW;
          if (tx_cnt_q == TX_LAST) begin
            tx_cnt_d   = '0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  // Outputs decode registered state only; the shift register is zero once drained
  assign out_bits  = {tx_state_q == TX_SEND, in_ack_q, tx_sh_q[DW-1:0]};
  assign rsp_ready = (tx_state_q == TX_IDLE);
  assign req_valid = req_valid_q;
  assign req_data  = asm_q[REQ_W-1:0];

endmodule

// File: tb/tb_chip_io_bridge.sv
// tb/tb_chip_io_bridge.sv - directed scoreboard bench for chip_io_bridge
module tb_chip_io_bridge;

  logic        clk;
  logic        reset_n;
  logic [11:0] in_bits;
  logic [11:0] out_bits;
  logic        req_valid;
  logic        req_ready;
  logic [39:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rx_timeout;

  logic        in_valid;
  logic        out_ready;
  logic [9:0]  in_data;
  logic        out_valid;
  logic        in_ack;
  logic [9:0]  out_data;

  assign in_bits   = {in_valid, out_ready, in_data};
  assign out_valid = out_bits[11];
  assign in_ack    = out_bits[10];
  assign out_data  = out_bits[9:0];

  chip_io_bridge #(
    .PAD_W(12), .REQ_W(40), .RSP_W(32), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_bits(in_bits), .out_bits(out_bits),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rx_timeout(rx_timeout)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [39:0] req_q[$];
  logic [9:0]  rsp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pack4(input logic [9:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic push_rsp(input logic [31:0] d);
    logic [39:0] w;
    w = {8'h00, d};
    for (int i = 0; i < 4; i++) rsp_q.push_back(w[i*10 +: 10]);
  endtask

  task automatic send_beat(input logic [9:0] d);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    while (!in_ack && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check("in_ack_wait", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [9:0] b0, b1, b2, b3);
    req_q.push_back(pack4(b0, b1, b2, b3));
    send_beat(b0);
    send_beat(b1);
    send_beat(b2);
    send_beat(b3);
  endtask

  // Scoreboard: compare every transfer the DUT offers against queued expectations
  always @(negedge clk) begin
    if (reset_n) begin
      if (req_valid && req_ready) begin
        if (req_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
        else check("req_data", 64'(req_data), 64'(req_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
        else check("out_data", 64'(out_data), 64'(rsp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int pat[10];
    logic [9:0] prev;
    logic stalled;
    logic saw;
    pat = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    #12;
    check("rst_out_bits", 64'(out_bits), 64'd0);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_data", 64'(req_data), 64'd0);
    check("rst_rx_timeout", 64'(rx_timeout), 64'd0);
    check("rst_rsp_ready", 64'(rsp_ready), 64'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    check("in_ack_after_rst", 64'(in_ack), 64'd1);

    // Basic request assembly
    req_ready = 1'b1;
    send_frame(10'h001, 10'h002, 10'h003, 10'h004);
    check("t1_req_data_const", 64'(req_data), 64'h0100300801);
    check("t1_req_valid", 64'(req_valid), 64'd1);
    check("t1_in_ack_low", 64'(in_ack), 64'd0);
    tick();
    check("t1_req_valid_drop", 64'(req_valid), 64'd0);
    check("t1_in_ack_back", 64'(in_ack), 64'd1);

    // Basic response serialisation
    out_ready = 1'b1;
    rsp_data  = 32'hDEADBEEF;
    rsp_valid = 1'b1;
    push_rsp(32'hDEADBEEF);
    tick();
    rsp_valid = 1'b0;
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_first_beat", 64'(out_data), 64'h2EF);
    for (int i = 0; i < 3; i++) begin
      check("t2_rsp_ready_busy", 64'(rsp_ready), 64'd0);
      tick();
    end
    check("t2_last_beat", 64'(out_data), 64'h003);
    tick();
    check("t2_rsp_ready_idle", 64'(rsp_ready), 64'd1);
    check("t2_out_valid_idle", 64'(out_valid), 64'd0);
    check("t2_rsp_drained", 64'(rsp_q.size()), 64'd0);
    out_ready = 1'b0;

    // Back-pressure on the request side
    req_ready = 1'b0;
    send_frame(10'h155, 10'h2AA, 10'h0F0, 10'h00F);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 10'($urandom);
      check("t3_hold_data", 64'(req_data), 64'(pack4(10'h155, 10'h2AA, 10'h0F0, 10'h00F)));
      check("t3_hold_ack", 64'(in_ack), 64'd0);
      check("t3_hold_valid", 64'(req_valid), 64'd1);
      tick();
    end
    in_valid  = 1'b0;
    req_ready = 1'b1;
    tick();
    check("t3_released", 64'(req_valid), 64'd0);
    send_frame(10'h3C3, 10'h00A, 10'h1B5, 10'h2FE);
    tick();
    check("t3_req_drained", 64'(req_q.size()), 64'd0);

    // Output stalls with an irregular out_ready pattern
    rsp_data  = 32'h12345678;
    rsp_valid = 1'b1;
    push_rsp(32'h12345678);
    tick();
    rsp_valid = 1'b0;
    k = 0;
    stalled = 1'b0;
    prev = '0;
    while (!rsp_ready && k < 40) begin
      if (stalled) check("t4_hold_stable", 64'(out_data), 64'(prev));
      out_ready = pat[k % 10] != 0;
      stalled   = !out_ready;
      prev      = out_data;
      tick();
      k++;
    end
    check("t4_done", 64'(rsp_ready), 64'd1);
    check("t4_rsp_drained", 64'(rsp_q.size()), 64'd0);
    out_ready = 1'b0;

    // Asynchronous reset mid-frame
    send_beat(10'h3FF);
    send_beat(10'h3FF);
    rsp_data  = 32'hCAFEF00D;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("t5_pre_out_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_out_bits", 64'(out_bits), 64'd0);
    check("t5_rst_req_data", 64'(req_data), 64'd0);
    check("t5_rst_req_valid", 64'(req_valid), 64'd0);
    check("t5_rst_rsp_ready", 64'(rsp_ready), 64'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    send_frame(10'h011, 10'h022, 10'h033, 10'h044);
    tick();
    check("t5_req_drained", 64'(req_q.size()), 64'd0);

    // Partial-request timeout
    send_beat(10'h0AB);
    send_beat(10'h0CD);
`ifdef CHIP_IO_BRIDGE_TIMEOUT_EN
    k = 0;
    while (!rx_timeout && k < 20) begin
      tick();
      k++;
    end
    check("t6_timeout_delay", 64'(k), 64'd8);
    tick();
    check("t6_timeout_pulse_end", 64'(rx_timeout), 64'd0);
    send_frame(10'h101, 10'h202, 10'h303, 10'h004);
`else
    saw = 1'b0;
    for (int i = 0; i < 300; i++) begin
      saw = saw | rx_timeout;
      tick();
    end
    check("t6_no_timeout", 64'(saw), 64'd0);
    req_q.push_back(pack4(10'h0AB, 10'h0CD, 10'h303, 10'h004));
    send_beat(10'h303);
    send_beat(10'h004);
`endif
    tick();
    tick();
    check("t6_req_drained", 64'(req_q.size()), 64'd0);
    check("final_rsp_drained", 64'(rsp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/chip_io_bridge.md
Name: chip_io_bridge

Overview:
- Parametrised pad-level bridge between the narrow chip pins and the multicore cache system's wide request/response channels.
- Inbound: multi-beat pad words are assembled into one REQ_W-bit request, presented with valid/ready.
- Outbound: each RSP_W-bit response is serialised into multi-beat pad words.
- Replaces hard-wired fixed-width pin use. Sits directly under the chip top, between the pads and the cache wrapper.

Parameters:
- PAD_W, 12, pad bus width in each direction; the data field is DW = PAD_W-2 bits.
- REQ_W, 40, request width. REQ_BEATS = ceil(REQ_W/DW).
- RSP_W, 32, response width. RSP_BEATS = ceil(RSP_W/DW).
- TIMEOUT_CYC, 255, idle-cycle limit for a partial request; used only with CHIP_IO_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_bits  in  PAD_W  pad input: {in_valid, out_ready, in_data[DW-1:0]}.
- out_bits  out  PAD_W  pad output: {out_valid, in_ack, out_data[DW-1:0]}.
- req_valid  out  1  assembled request valid.
- req_ready  in  1  core accepts request.
- req_data  out  REQ_W  assembled request.
- rsp_valid  in  1  core response valid.
- rsp_ready  out  1  bridge can take a response.
- rsp_data  in  RSP_W  core response.
- rx_timeout  out  1  one-cycle pulse: partial request discarded.

Behaviour:
- Reset is asynchronous, active-low. The following are cleared: both FSMs to their first state, all counters, data registers, and every output (out_bits=0, req_valid=0, req_data=0, rx_timeout=0). rsp_ready comes from state, so it is 1 right after reset.
- Pad beat transfer rules:
  - An input beat transfers on a rising edge where in_valid=1 and in_ack=1.
  - An output beat transfers on a rising edge where out_valid=1 and out_ready=1.
  - in_ack, out_valid and out_data are decoded from registered state only; there is no combinational pad-to-pad path.
- RX FSM: RX_COLLECT -> RX_HOLD.
  - RX_COLLECT: in_ack=1, req_valid=0. Each accepted beat is written into DW-bit field beat_cnt of the assembly register; beat 0 is the LSBs.
  - The last field is truncated to REQ_W. Its excess upper pad bits are ignored.
  - On acceptance of beat REQ_BEATS-1: go to RX_HOLD and clear beat_cnt.
  - RX_HOLD: req_valid=1, in_ack=0, req_data stable. On req_ready=1, return to RX_COLLECT; in_ack=1 on the next cycle.
  - Latency: req_valid rises the cycle after the last beat is accepted.
  - in_valid while in_ack=0 is not a transfer and is ignored; the host must hold the beat.
- TX FSM: TX_IDLE -> TX_SEND.
  - TX_IDLE: rsp_ready=1, out_valid=0. On rsp_valid=1, capture rsp_data into the shift register, clear tx_cnt, go to TX_SEND.
  - TX_SEND: rsp_ready=0, out_valid=1, out_data = field tx_cnt, with LSB field first. Bits beyond RSP_W in the last beat are driven 0.
  - On an output transfer: tx_cnt++. Transfer of beat RSP_BEATS-1 returns the FSM to TX_IDLE.
  - There is one idle cycle between back-to-back responses.
  - out_ready=0 holds the current beat stable indefinitely.
- RX and TX are fully independent. Simultaneous input and output beats in the same cycle are both legal.
- A DW that does not divide the width evenly is legal. Every beat counter is sized to clog2(BEATS) and must not wrap beyond BEATS-1.
- Reset asserted mid-frame discards partial RX/TX state. No partial request or response is ever emitted.

Optional Feature:
- Macro: CHIP_IO_BRIDGE_TIMEOUT_EN.
- Defined:
  - An idle counter runs while RX_COLLECT has beat_cnt != 0. It clears on every accepted beat.
  - When it reaches TIMEOUT_CYC, beat_cnt is cleared, the partial data is dropped, and rx_timeout pulses high for 1 cycle. The FSM stays in RX_COLLECT.
  - With beat_cnt == 0, the counter holds at 0.
- Undefined: no counter logic; rx_timeout is tied to 0; partial requests wait forever.

Test Plan:
- Defaults; input beats 0x001,0x002,0x003,0x004 with req_ready=1 -> the cycle after beat 4, req_valid=1 for 1 cycle with req_data=40'h0100300801; in_ack low exactly that cycle.
- rsp_data=32'hDEADBEEF, out_ready=1 -> out_data beats 0x2EF,0x36F,0x1EA,0x003 on consecutive cycles; rsp_ready=0 during send; rsp_ready=1 again after the last beat.
- Request assembled with req_ready=0 for 10 cycles -> req_data is stable, in_ack=0, and extra in_valid beats are ignored; req_ready=1 -> release, and the next frame assembles correctly.
- out_ready toggled 1,0,0,1,... during a response -> each beat is held while stalled; no beat is skipped or duplicated.
- reset_n asserted asynchronously after 2 of 4 input beats -> all outputs are 0 immediately. After release, a fresh 4-beat frame yields the correct req_data, with no leftover from the earlier fields.
- CHIP_IO_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=8: 2 beats then idle -> rx_timeout pulses once 8 cycles after the last beat; the next 4 beats form a clean request. With the macro undefined, rx_timeout stays 0.
